// File: rtl/pipeline_trace_pkg.sv
// Shared types and helpers for the pipeline trace capture buffer.
// Optional build macro TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to each entry.
package pipeline_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'b00;
  localparam logic [1:0] TRIG_PCSRC     = 2'b01;
  localparam logic [1:0] TRIG_INSTR     = 2'b10;
  localparam logic [1:0] TRIG_ALU       = 2'b11;

  localparam int unsigned TS_W = 16;

  // Entry layout: {[ts,] pcsrc_e, flags, instr, alu_result, src_a, src_b}
  function automatic int unsigned entry_width(input int unsigned instr_w,
                                              input int unsigned data_w,
                                              input int unsigned flag_w,
                                              input int unsigned ts_w);
    return 1 + flag_w + instr_w + 3 * data_w + ts_w;
  endfunction

endpackage

// File: rtl/pipeline_trace_capture_ram.sv
// Simple dual-port trace storage: synchronous write, synchronous read with enable.
// Read data holds its value while i_re is low, so it doubles as a pipeline stage.
module trace_ram #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 45,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pipeline_trace_capture.sv
// Circular trace buffer for CPU debug signals, captured around a trigger and streamed oldest-first.
// Define TRACE_TIMESTAMP_EN to prepend a free-running 16-bit cycle counter to every entry.
module pipeline_trace_capture
  import pipeline_trace_pkg::*;
#(
  parameter  int unsigned INSTR_W   = 16,
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned FLAG_W    = 4,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned POST_TRIG = 4,
`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned ENTRY_W   = entry_width(INSTR_W, DATA_W, FLAG_W, TS_W),
`else
  localparam int unsigned ENTRY_W   = entry_width(INSTR_W, DATA_W, FLAG_W, 0),
`endif
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [INSTR_W-1:0] instr,
  input  logic [FLAG_W-1:0]  flags,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  input  logic               pcsrc_e,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [INSTR_W-1:0] trig_mask,
  input  logic [INSTR_W-1:0] trig_value,
  output logic               busy,
  output logic               triggered,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_last,
  output logic [AW-1:0]      trig_pos
);

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0]      r_wr_ptr;
  logic [AW:0]        r_count;
  logic [AW-1:0]      r_post_cnt;
  logic               r_busy;
  logic               r_triggered;
  logic [AW-1:0]      r_trig_pos;

  logic [AW:0]        r_fetch_idx;
  logic               r_a_vld;
  logic               r_a_last;
  logic               r_rd_valid;
  logic               r_rd_last;
  logic [ENTRY_W-1:0] r_rd_data;

  logic               w_trig_hit;
  logic               w_fire;
  logic               w_capture;
  logic               w_arm_go;
  logic [AW:0]        w_count_inc;
  logic               w_beat;
  logic               w_a_move;
  logic               w_issue;
  logic [AW-1:0]      w_start;
  logic [AW-1:0]      w_raddr;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_ram_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  assign w_entry = {r_ts, pcsrc_e, flags, instr, alu_result, src_a, src_b};
`else
  assign w_entry = {pcsrc_e, flags, instr, alu_result, src_a, src_b};
`endif

  // Trigger condition; qualified by state and sample_en below
  always_comb begin
    w_trig_hit = 1'b0;
    case (trig_mode)
      TRIG_IMMEDIATE: w_trig_hit = 1'b1;
      TRIG_PCSRC:     w_trig_hit = pcsrc_e;
      TRIG_INSTR:     w_trig_hit = ((instr & trig_mask) == trig_value);
      TRIG_ALU:       w_trig_hit = (alu_result == trig_value[DATA_W-1:0]);
      default:        w_trig_hit = 1'b0;
    endcase
  end

  assign w_capture   = ((r_state == ARMED) || (r_state == POST)) && sample_en && !abort;
  assign w_fire      = (r_state == ARMED) && sample_en && w_trig_hit && !abort;
  assign w_arm_go    = (r_state == IDLE) && arm;
  assign w_count_inc = (r_count == (AW+1)'(DEPTH)) ? r_count : r_count + (AW+1)'(1);

  // Readout: RAM output register is the first stage, rd_data the second
  assign w_beat   = r_rd_valid && rd_ready;
  assign w_a_move = r_a_vld && (!r_rd_valid || w_beat);
  assign w_issue  = (r_state == DONE) && (r_fetch_idx < r_count) && (!r_a_vld || w_a_move);
  assign w_start  = (r_count == (AW+1)'(DEPTH)) ? r_wr_ptr : '0;
  assign w_raddr  = w_start + r_fetch_idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (arm) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (w_fire) w_state_nxt = (POST_TRIG == 0) ? DONE : POST;
      end
      POST: begin
        if (sample_en && (r_post_cnt == AW'(POST_TRIG - 1))) w_state_nxt = DONE;
      end
      DONE: begin
        if (w_beat && r_rd_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // Capture side: write pointer, fill level, post-trigger counter, status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_post_cnt  <= '0;
      r_busy      <= 1'b0;
      r_triggered <= 1'b0;
      r_trig_pos  <= '0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      if (abort || w_arm_go) begin
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_post_cnt  <= '0;
        r_triggered <= 1'b0;
      end else begin
        if (w_capture) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_count  <= w_count_inc;
        end
        if (w_fire) begin
          r_triggered <= 1'b1;
          r_post_cnt  <= '0;
        end else if ((r_state == POST) && sample_en) begin
          r_post_cnt <= r_post_cnt + AW'(1);
        end else if ((r_state == DONE) && (w_state_nxt == IDLE)) begin
          r_triggered <= 1'b0;
        end
      end
      // DONE is only entered on a capture cycle, so the final fill level is w_count_inc
      if ((w_state_nxt == DONE) && (r_state != DONE)) begin
        r_trig_pos <= AW'(w_count_inc - (AW+1)'(POST_TRIG + 1));
      end
    end
  end

  // Read side: prefetch through the RAM register into the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_idx <= '0;
      r_a_vld     <= 1'b0;
      r_a_last    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
    end else if ((r_state != DONE) || (w_state_nxt != DONE)) begin
      r_fetch_idx <= '0;
      r_a_vld     <= 1'b0;
      r_a_last    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_fetch_idx <= r_fetch_idx + (AW+1)'(1);
        r_a_last    <= (r_fetch_idx == r_count - (AW+1)'(1));
        r_a_vld     <= 1'b1;
      end else if (w_a_move) begin
        r_a_vld <= 1'b0;
      end
      if (w_a_move) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_ram_q;
        r_rd_last  <= r_a_last;
      end else if (w_beat) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_capture),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_entry),
    .i_re    (w_issue),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  assign busy      = r_busy;
  assign triggered = r_triggered;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign trig_pos  = r_trig_pos;

endmodule

// File: tb/tb_pipeline_trace_capture.sv
// Directed bench for pipeline_trace_capture at default parameters (DEPTH 16, POST_TRIG 4).
module tb_pipeline_trace_capture;

`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = 61;
`else
  localparam int EW = 45;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_en;
  logic [15:0]   instr;
  logic [3:0]    flags;
  logic [7:0]    alu_result;
  logic [7:0]    src_a;
  logic [7:0]    src_b;
  logic          pcsrc_e;
  logic          arm;
  logic          abort;
  logic [1:0]    trig_mode;
  logic [15:0]   trig_mask;
  logic [15:0]   trig_value;
  logic          busy;
  logic          triggered;
  logic          rd_valid;
  logic          rd_ready;
  logic [EW-1:0] rd_data;
  logic          rd_last;
  logic [3:0]    trig_pos;

  int errors = 0;
  int checks = 0;

  logic [44:0] got [32];
  int          got_n;
  int          last_idx;
  int          stall_viol;
  int          first_cyc;
  int          last_cyc;
  bit          timed_out;

  always #5 clk = ~clk;

  pipeline_trace_capture dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .instr      (instr),
    .flags      (flags),
    .alu_result (alu_result),
    .src_a      (src_a),
    .src_b      (src_b),
    .pcsrc_e    (pcsrc_e),
    .arm        (arm),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .busy       (busy),
    .triggered  (triggered),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .trig_pos   (trig_pos)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] def_instr(input int k);
    return 16'(16'h1000 + k);
  endfunction

  // {pcsrc_e, flags, instr, alu_result, src_a, src_b} for sample k
  function automatic logic [44:0] exp_entry(input int k, input logic pc, input logic [15:0] ins);
    return {pc, 4'(k), ins, 8'(k), 8'(255 - k), 8'(k) | 8'h80};
  endfunction

  task automatic drive_sample(input int k, input logic pc, input logic [15:0] ins);
    sample_en  = 1'b1;
    instr      = ins;
    flags      = 4'(k);
    alu_result = 8'(k);
    src_a      = 8'(255 - k);
    src_b      = 8'(k) | 8'h80;
    pcsrc_e    = pc;
    step();
    sample_en  = 1'b0;
    pcsrc_e    = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] mode);
    trig_mode = mode;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Gathers beats until rd_last; records stall stability and beat timing, no pass/fail here
  task automatic collect(input bit toggle, input int max_cyc);
    logic [EW-1:0] held;
    bit            have_held;
    int            cyc;
    bit            done;
    got_n = 0; last_idx = -1; stall_viol = 0; first_cyc = -1; last_cyc = -1;
    timed_out = 1'b0; have_held = 1'b0; cyc = 0; done = 1'b0; held = '0;
    while (!done) begin
      if (cyc >= max_cyc || got_n >= 32) begin
        timed_out = 1'b1;
        break;
      end
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (have_held && (!rd_valid || rd_data !== held)) stall_viol++;
      have_held = 1'b0;
      if (rd_valid && rd_ready) begin
        got[got_n] = rd_data[44:0];
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (rd_last) begin
          last_idx = got_n;
          done = 1'b1;
        end
        got_n++;
      end else if (rd_valid) begin
        held = rd_data;
        have_held = 1'b1;
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({busy, triggered, rd_valid, rd_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: got %b want 0000", {busy, triggered, rd_valid, rd_last});
    end
    checks++;
    if (rd_data !== '0 || trig_pos !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: rd_data=%h trig_pos=%0d want 0/0", rd_data, trig_pos);
    end
  endtask

  task automatic test_immediate();
    do_arm(2'b00);
    checks++;
    if (busy !== 1'b1 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL imm_armed: busy=%b triggered=%b want 1/0", busy, triggered);
    end
    drive_sample(0, 1'b0, def_instr(0));
    checks++;
    if (triggered !== 1'b1) begin
      errors++;
      $display("FAIL imm_triggered: got %b want 1", triggered);
    end
    for (int k = 1; k <= 4; k++) drive_sample(k, 1'b0, def_instr(k));
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL imm_done_entry: rd_valid=%b busy=%b want 0/1", rd_valid, busy);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL imm_valid_early: got %b want 0", rd_valid);
    end
    step();
    checks++;
    if (rd_valid !== 1'b1 || trig_pos !== 4'd0) begin
      errors++;
      $display("FAIL imm_valid_rise: rd_valid=%b trig_pos=%0d want 1/0", rd_valid, trig_pos);
    end
    collect(1'b0, 40);
    checks++;
    if (timed_out || got_n != 5 || last_idx != 4) begin
      errors++;
      $display("FAIL imm_count: beats=%0d last_idx=%0d timeout=%0d want 5/4/0", got_n, last_idx, timed_out);
    end
    for (int i = 0; i < 5 && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp_entry(i, 1'b0, def_instr(i))) begin
        errors++;
        $display("FAIL imm_entry%0d: got %h want %h", i, got[i], exp_entry(i, 1'b0, def_instr(i)));
      end
    end
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL imm_idle: busy=%b rd_valid=%b triggered=%b want 000", busy, rd_valid, triggered);
    end
  endtask

  task automatic test_pcsrc_wrap();
    do_arm(2'b01);
    // samples 25..29 arrive in DONE and must not be written
    for (int k = 0; k < 30; k++) drive_sample(k, (k == 20), def_instr(k));
    checks++;
    if (trig_pos !== 4'd11 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL pc_trig_pos: trig_pos=%0d triggered=%b want 11/1", trig_pos, triggered);
    end
    collect(1'b0, 60);
    checks++;
    if (timed_out || got_n != 16 || last_idx != 15) begin
      errors++;
      $display("FAIL pc_count: beats=%0d last_idx=%0d timeout=%0d want 16/15/0", got_n, last_idx, timed_out);
    end
    checks++;
    if (last_cyc - first_cyc != 15) begin
      errors++;
      $display("FAIL pc_back_to_back: span=%0d want 15", last_cyc - first_cyc);
    end
    for (int i = 0; i < 16 && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp_entry(9 + i, (i == 11), def_instr(9 + i))) begin
        errors++;
        $display("FAIL pc_entry%0d: got %h want %h", i, got[i], exp_entry(9 + i, (i == 11), def_instr(9 + i)));
      end
    end
  endtask

  task automatic test_instr_match();
    trig_mask  = 16'hF000;
    trig_value = 16'hA000;
    do_arm(2'b10);
    for (int k = 0; k < 7; k++) drive_sample(k, 1'b0, def_instr(k));
    checks++;
    if (triggered !== 1'b0) begin
      errors++;
      $display("FAIL instr_early_trig: got %b want 0", triggered);
    end
    drive_sample(7, 1'b0, 16'hA123);
    checks++;
    if (triggered !== 1'b1) begin
      errors++;
      $display("FAIL instr_triggered: got %b want 1", triggered);
    end
    for (int k = 8; k < 12; k++) drive_sample(k, 1'b0, def_instr(k));
    collect(1'b0, 50);
    checks++;
    if (timed_out || got_n != 12 || trig_pos !== 4'd7) begin
      errors++;
      $display("FAIL instr_count: beats=%0d trig_pos=%0d timeout=%0d want 12/7/0", got_n, trig_pos, timed_out);
    end
    checks++;
    if (got_n > 7 && got[7] !== exp_entry(7, 1'b0, 16'hA123)) begin
      errors++;
      $display("FAIL instr_entry7: got %h want %h", got[7], exp_entry(7, 1'b0, 16'hA123));
    end
    checks++;
    if (got_n > 0 && got[0] !== exp_entry(0, 1'b0, def_instr(0))) begin
      errors++;
      $display("FAIL instr_entry0: got %h want %h", got[0], exp_entry(0, 1'b0, def_instr(0)));
    end
    trig_mask  = 16'h0000;
    trig_value = 16'h0000;
  endtask

  task automatic test_ready_toggle();
    trig_value = 16'h0003;
    do_arm(2'b11);
    for (int k = 0; k < 8; k++) drive_sample(k, 1'b0, def_instr(k));
    collect(1'b1, 60);
    checks++;
    if (timed_out || got_n != 8 || last_idx != 7 || trig_pos !== 4'd3) begin
      errors++;
      $display("FAIL tog_count: beats=%0d last_idx=%0d trig_pos=%0d want 8/7/3", got_n, last_idx, trig_pos);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL tog_stable: violations=%0d want 0", stall_viol);
    end
    for (int i = 0; i < 8 && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp_entry(i, 1'b0, def_instr(i))) begin
        errors++;
        $display("FAIL tog_entry%0d: got %h want %h", i, got[i], exp_entry(i, 1'b0, def_instr(i)));
      end
    end
    trig_value = 16'h0000;
  endtask

  task automatic test_abort_rearm();
    do_arm(2'b01);
    for (int k = 0; k < 4; k++) drive_sample(k, (k == 2), def_instr(k));
    checks++;
    if (busy !== 1'b1 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: busy=%b triggered=%b want 1/1", busy, triggered);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || triggered !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_post: busy=%b triggered=%b rd_valid=%b want 000", busy, triggered, rd_valid);
    end
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_arm: busy=%b want 0", busy);
    end
    do_arm(2'b00);
    for (int k = 100; k < 105; k++) drive_sample(k, 1'b0, def_instr(k));
    collect(1'b0, 40);
    checks++;
    if (timed_out || got_n != 5 || trig_pos !== 4'd0) begin
      errors++;
      $display("FAIL rearm_count: beats=%0d trig_pos=%0d want 5/0", got_n, trig_pos);
    end
    checks++;
    if (got[0] !== exp_entry(100, 1'b0, def_instr(100)) || got[4] !== exp_entry(104, 1'b0, def_instr(104))) begin
      errors++;
      $display("FAIL rearm_entries: first=%h last=%h want %h %h", got[0], got[4],
               exp_entry(100, 1'b0, def_instr(100)), exp_entry(104, 1'b0, def_instr(104)));
    end
  endtask

  task automatic test_reset_mid_stream();
    do_arm(2'b00);
    for (int k = 0; k < 5; k++) drive_sample(k, 1'b0, def_instr(k));
    step();
    step();
    rd_ready = 1'b1;
    step();
    checks++;
    if (rd_valid !== 1'b1 || triggered !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: rd_valid=%b triggered=%b busy=%b want 111", rd_valid, triggered, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: rd_valid=%b busy=%b triggered=%b want 000", rd_valid, busy, triggered);
    end
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; instr = '0; flags = '0; alu_result = '0;
    src_a = '0; src_b = '0; pcsrc_e = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_mode = 2'b00; trig_mask = '0; trig_value = '0; rd_ready = 1'b0;
    test_reset();
    test_immediate();
    test_pcsrc_wrap();
    test_instr_match();
    test_ready_toggle();
    test_abort_rearm();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
